// File: rtl/sys_defs.sv
// Shared definitions for the front end: fetch FSM encoding, fetch-to-decode
// bundle and the default reset PC.
package sys_defs;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [1:0][31:0] ir;
        logic [1:0][63:0] npc;
        logic [1:0]       valid;
    } FETCH_DEC_OUT_t;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_stage.sv
// Two-wide fetch stage: one outstanding I-cache request, holds the returned
// pair until decode takes it, and recovers from branch rollbacks.
module fetch_stage
    import sys_defs::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rollback_en,
    input  logic [63:0]      rollback_target,
    output logic             icache_req_valid,
    output logic [63:0]      icache_req_addr,
    input  logic             icache_rsp_valid,
    input  logic [63:0]      icache_rsp_data,
    output logic [1:0][31:0] if_IR_out,
    output logic [1:0][63:0] if_NPC_out,
    output logic [1:0]       if_inst_valid,
    input  logic             bp_take_branch,
    input  logic [63:0]      bp_target,
    input  logic [1:0]       bp_inst_valid,
    input  logic             dec_ready,
    output logic [1:0]       dec_valid
);

    fetch_state_t     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [1:0][31:0] ir_q, ir_d;

    logic [63:0]      pc_aligned;
    FETCH_DEC_OUT_t   fetch_out;

    assign pc_aligned = {pc_q[63:3], 3'b000};

    assign icache_req_valid = (state_q == FETCH);
    assign icache_req_addr  = pc_aligned;

    // Slot 0 is skipped when the PC points at the upper half of the pair.
    always_comb begin
        fetch_out.ir     = ir_q;
        fetch_out.npc[0] = pc_aligned + 64'd4;
        fetch_out.npc[1] = pc_aligned + 64'd8;
        fetch_out.valid  = 2'b00;
        if (state_q == HOLD) begin
            fetch_out.valid = {1'b1, ~pc_q[2]};
        end
    end

    assign if_IR_out     = fetch_out.ir;
    assign if_NPC_out    = fetch_out.npc;
    assign if_inst_valid = fetch_out.valid;
    assign dec_valid     = (state_q == HOLD && !rollback_en) ? (bp_inst_valid & fetch_out.valid) : 2'b00;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (rollback_en) begin
            pc_d = rollback_target;
            case (state_q)
                FETCH:   state_d = icache_rsp_valid ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                default: state_d = DRAIN;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (icache_rsp_valid) begin
                        ir_d[0] = icache_rsp_data[31:0];
                        ir_d[1] = icache_rsp_data[63:32];
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        pc_d    = bp_take_branch ? bp_target : (pc_aligned + 64'd8);
                        state_d = FETCH;
                    end
                end
                // The response still in flight belongs to the squashed path.
                DRAIN: begin
                    if (icache_rsp_valid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: walks the fetch/hold/drain paths with
// hand-computed expectations.
module tb_fetch_stage;

    logic             clock;
    logic             reset;
    logic             rollback_en;
    logic [63:0]      rollback_target;
    logic             icache_req_valid;
    logic [63:0]      icache_req_addr;
    logic             icache_rsp_valid;
    logic [63:0]      icache_rsp_data;
    logic [1:0][31:0] if_IR_out;
    logic [1:0][63:0] if_NPC_out;
    logic [1:0]       if_inst_valid;
    logic             bp_take_branch;
    logic [63:0]      bp_target;
    logic [1:0]       bp_inst_valid;
    logic             dec_ready;
    logic [1:0]       dec_valid;

    int checks_cnt;
    int fail_cnt;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .rollback_en     (rollback_en),
        .rollback_target (rollback_target),
        .icache_req_valid(icache_req_valid),
        .icache_req_addr (icache_req_addr),
        .icache_rsp_valid(icache_rsp_valid),
        .icache_rsp_data (icache_rsp_data),
        .if_IR_out       (if_IR_out),
        .if_NPC_out      (if_NPC_out),
        .if_inst_valid   (if_inst_valid),
        .bp_take_branch  (bp_take_branch),
        .bp_target       (bp_target),
        .bp_inst_valid   (bp_inst_valid),
        .dec_ready       (dec_ready),
        .dec_valid       (dec_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rollback_en      = 1'b0;
        rollback_target  = 64'h0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = 64'h0;
        bp_take_branch   = 1'b0;
        bp_target        = 64'h0;
        bp_inst_valid    = 2'b11;
        dec_ready        = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_req_valid", {63'h0, icache_req_valid}, 64'h1);
        check("rst_req_addr",  icache_req_addr, 64'h0);
        check("rst_dec_valid", {62'h0, dec_valid}, 64'h0);
        check("rst_inst_valid",{62'h0, if_inst_valid}, 64'h0);
        check("rst_ir0",       {32'h0, if_IR_out[0]}, 64'h0);

        // Basic fetch from 0, consumed immediately
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'hBBBB0002_AAAA0001;
        tick();
        idle_inputs();
        dec_ready = 1'b1;
        #1;
        check("b_dec_valid", {62'h0, dec_valid}, 64'h3);
        check("b_req_valid", {63'h0, icache_req_valid}, 64'h0);
        check("b_ir0",  {32'h0, if_IR_out[0]}, 64'hAAAA0001);
        check("b_ir1",  {32'h0, if_IR_out[1]}, 64'hBBBB0002);
        check("b_npc0", if_NPC_out[0], 64'h4);
        check("b_npc1", if_NPC_out[1], 64'h8);
        // Redirect to 0x104 via the predictor
        bp_take_branch = 1'b1;
        bp_target      = 64'h104;
        tick();
        idle_inputs();
        #1;
        check("b_next_addr", icache_req_addr, 64'h100);
        check("b_next_req",  {63'h0, icache_req_valid}, 64'h1);

        // Odd-slot PC: slot 0 invalid; then stall three cycles
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'hDDDD0004_CCCC0003;
        tick();
        idle_inputs();
        #1;
        check("o_inst_valid", {62'h0, if_inst_valid}, 64'h2);
        check("o_npc0", if_NPC_out[0], 64'h104);
        check("o_npc1", if_NPC_out[1], 64'h108);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s_dec_valid", {62'h0, dec_valid}, 64'h2);
            check("s_req_valid", {63'h0, icache_req_valid}, 64'h0);
            check("s_ir1", {32'h0, if_IR_out[1]}, 64'hDDDD0004);
            check("s_npc1", if_NPC_out[1], 64'h108);
        end
        dec_ready = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("s_next_addr", icache_req_addr, 64'h108);

        // Predicted branch with BP masking slot 1
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'hFFFF0006_EEEE0005;
        tick();
        idle_inputs();
        dec_ready      = 1'b1;
        bp_take_branch = 1'b1;
        bp_target      = 64'h2000;
        bp_inst_valid  = 2'b01;
        #1;
        check("p_dec_valid", {62'h0, dec_valid}, 64'h1);
        tick();
        idle_inputs();
        #1;
        check("p_next_addr", icache_req_addr, 64'h2000);

        // Rollback in FETCH before the response -> drain the stale reply
        rollback_en     = 1'b1;
        rollback_target = 64'h400;
        #1;
        check("d_dec_valid", {62'h0, dec_valid}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("d_req_valid0", {63'h0, icache_req_valid}, 64'h0);
        tick();
        check("d_req_valid1", {63'h0, icache_req_valid}, 64'h0);
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'h11111111_22222222;
        tick();
        idle_inputs();
        #1;
        check("d_next_addr",  icache_req_addr, 64'h400);
        check("d_next_req",   {63'h0, icache_req_valid}, 64'h1);
        check("d_inst_valid", {62'h0, if_inst_valid}, 64'h0);
        check("d_ir0_kept",   {32'h0, if_IR_out[0]}, 64'hEEEE0005);

        // Rollback coincident with the response
        rollback_en      = 1'b1;
        rollback_target  = 64'h800;
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'h33333333_44444444;
        dec_ready        = 1'b1;
        #1;
        check("c_dec_valid", {62'h0, dec_valid}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("c_req_valid", {63'h0, icache_req_valid}, 64'h1);
        check("c_next_addr", icache_req_addr, 64'h800);
        check("c_ir0_kept",  {32'h0, if_IR_out[0]}, 64'hEEEE0005);

        // Rollback in HOLD beats decode consumption and the BP redirect
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'h55555555_66666666;
        tick();
        idle_inputs();
        rollback_en     = 1'b1;
        rollback_target = 64'hC00;
        dec_ready       = 1'b1;
        bp_take_branch  = 1'b1;
        bp_target       = 64'h3000;
        #1;
        check("h_dec_valid", {62'h0, dec_valid}, 64'h0);
        tick();
        idle_inputs();
        #1;
        check("h_next_addr", icache_req_addr, 64'hC00);

        // Reset during DRAIN: the late response is accepted as real
        rollback_en     = 1'b1;
        rollback_target = 64'h5000;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("r_req_addr", icache_req_addr, 64'h0);
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 64'h77777777_88888888;
        tick();
        idle_inputs();
        #1;
        check("r_inst_valid", {62'h0, if_inst_valid}, 64'h3);
        check("r_ir0", {32'h0, if_IR_out[0]}, 64'h88888888);

        // Aligned-address wrap of the next-sequential PCs
        dec_ready      = 1'b1;
        bp_take_branch = 1'b1;
        bp_target      = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        idle_inputs();
        icache_rsp_valid = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("w_npc0", if_NPC_out[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("w_npc1", if_NPC_out[1], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning first fetch address after reset.
REQ-002 SHALL have port clock  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rollback_en  input  1  branch-recovery flush from FU.
REQ-005 SHALL have port rollback_target  input  64  recovery PC.
REQ-006 SHALL have port icache_req_valid  output  1  fetch request to I-cache.
REQ-007 SHALL have port icache_req_addr  output  64  8-byte-aligned fetch address.
REQ-008 SHALL have port icache_rsp_valid  input  1  response for the outstanding request.
REQ-009 SHALL have port icache_rsp_data  input  64  two instructions; [31:0] = slot0, [63:32] = slot1.
REQ-010 SHALL have port if_IR_out  output  2x32  held instruction pair, to BP and decode.
REQ-011 SHALL have port if_NPC_out  output  2x64  per-slot next-sequential PC, to BP and decode.
REQ-012 SHALL have port if_inst_valid  output  2  raw slot validity, to BP (F_BP_out.inst_valid).
REQ-013 SHALL have port bp_take_branch  input  1  BP predicts redirect for the held pair.
REQ-014 SHALL have port bp_target  input  64  BP redirect target.
REQ-015 SHALL have port bp_inst_valid  input  2  BP-masked slot validity.
REQ-016 SHALL have port dec_ready  input  1  decode accepts the pair this cycle.
REQ-017 SHALL have port dec_valid  output  2  slot valid to decode.

Function
REQ-018 SHALL keep a 64-bit PC register and a 3-state FSM: FETCH, HOLD, DRAIN.
REQ-019 FETCH: icache_req_valid=1, icache_req_addr={PC[63:3],3'b000}; hold both stable until icache_rsp_valid.
REQ-020 FETCH with icache_rsp_valid: register data into the IR pair; next state HOLD.
REQ-021 HOLD: icache_req_valid=0; if_inst_valid[0]=!PC[2], if_inst_valid[1]=1; outside HOLD, if_inst_valid=2'b00.
REQ-022 if_NPC_out[0]={PC[63:3],3'b000}+4; if_NPC_out[1]={PC[63:3],3'b000}+8; 64-bit wrap, no overflow flag.
REQ-023 dec_valid = bp_inst_valid & if_inst_valid in HOLD, else 2'b00; BP path is combinational, same cycle.
REQ-024 HOLD with dec_ready: PC <= bp_take_branch ? bp_target : {PC[63:3],3'b000}+8; next state FETCH.
REQ-025 HOLD without dec_ready: all outputs and the PC are held unchanged.
REQ-026 Fetch-to-decode latency: response at cycle N gives dec_valid at N+1; at most one pair per 2 cycles.
REQ-027 rollback_en has priority over every other event: PC <= rollback_target and dec_valid=2'b00 that cycle.
REQ-028 Rollback in HOLD, or in FETCH coincident with icache_rsp_valid: discard the pair; next state FETCH.
REQ-029 Rollback in FETCH without icache_rsp_valid: next state DRAIN; request deasserted.
REQ-030 DRAIN: icache_req_valid=0; drop the next icache_rsp_valid; then go to FETCH with the new PC.
REQ-031 Rollback in DRAIN: update PC only; stay in DRAIN.
REQ-032 icache_rsp_valid in HOLD is a protocol error and SHALL be ignored.

Reset
REQ-033 On reset: PC=RESET_PC, state=FETCH, IR pair=0, dec_valid=0, if_inst_valid=0.
REQ-034 First cycle after reset: icache_req_valid=1, icache_req_addr=RESET_PC aligned.
REQ-035 Reset mid-DRAIN or mid-HOLD SHALL abandon all state; a late response is then treated as valid (cache reset together).

Structure
REQ-036 The FSM state enum, a FETCH_DEC_OUT_t struct (IR, NPC, valid) and RESET_PC default SHALL live in the shared sys_defs package.
REQ-037 Single module; no sub-module.

Verification
REQ-038 Reset, RESET_PC=0, rsp at cycle 2 with data {I1,I0}, dec_ready=1, no branch -> dec_valid=11 at cycle 3, NPC=4/8, next req_addr=8.
REQ-039 PC=0x104 (PC[2]=1) -> req_addr=0x100, if_inst_valid=10, NPC1=0x108.
REQ-040 HOLD, bp_take_branch=1, bp_target=0x2000, bp_inst_valid=01 -> dec_valid=01, next req_addr=0x2000.
REQ-041 dec_ready=0 for 3 cycles in HOLD -> IR/NPC/dec_valid stable, no request; consumed on the 4th cycle.
REQ-042 Rollback to 0x400 in FETCH before rsp; rsp 2 cycles later with stale data -> data dropped, next req_addr=0x400, no dec_valid.
REQ-043 Rollback coincident with rsp_valid and dec_ready -> dec_valid=00, next cycle FETCH with req_addr=rollback_target.
